// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types, widths and round-robin search for the FIFO write arbiter
package fifo_arb_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;
  localparam int BEAT_W = 4;
  function automatic logic [2:0] rr_next(input logic [7:0] mask, input logic [2:0] last, input int n);
    logic [2:0] w;
    int idx;
    w = last;
    for (int i = n; i >= 1; i--) begin
      idx = (int'(last) + i) % n;
      if (mask[idx]) w = 3'(idx);
    end
    return w;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner search starting after last_grant
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [GW-1:0]    last_grant,
  output logic [GW-1:0]    winner,
  output logic             any
);
  assign winner = GW'(rr_next(8'(req_valid), 3'(last_grant), N_REQ));
  assign any = |req_valid;
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter sharing the async FIFO write port
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int D_WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                       w_clk,
  input  logic                       w_rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*D_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]           req_ready,
  input  logic                       wfull,
  input  logic                       hfull,
  output logic                       w_inc,
  output logic [D_WIDTH-1:0]         wdata,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy
);
  localparam int GW = $clog2(N_REQ);
  arb_state_t state;
  logic [GW-1:0] last_grant, winner;
  logic [BEAT_W-1:0] beat_cnt, lim;
  logic any, bubble, xfer, rel;
  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_valid (req_valid),
    .last_grant(last_grant),
    .winner    (winner),
    .any       (any)
  );
  assign busy = state == GRANT;
  assign xfer = busy && req_valid[grant_id] && !wfull;
  assign lim = hfull ? BEAT_W'(1) : BEAT_W'(BURST);
  // >= rather than == so hfull rising mid-burst still ends the grant on the next beat
  assign rel = busy && ((xfer && beat_cnt + 1'b1 >= lim) || !req_valid[grant_id]);
  assign w_inc = xfer;
  assign req_ready = xfer ? {{(N_REQ-1){1'b0}}, 1'b1} << grant_id : '0;
  assign wdata = busy ? req_data[int'(grant_id)*D_WIDTH +: D_WIDTH] : '0;
  // bubble marks the mandatory dead IDLE cycle that follows every release
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state <= IDLE;
      last_grant <= GW'(N_REQ-1);
      grant_id <= '0;
      beat_cnt <= '0;
      bubble <= 1'b0;
    end else if (!busy) begin
      bubble <= 1'b0;
      if (!bubble && any && !wfull) begin
        state <= GRANT;
        grant_id <= winner;
        beat_cnt <= '0;
      end
    end else if (rel) begin
      state <= IDLE;
      last_grant <= grant_id;
      bubble <= 1'b1;
    end else if (xfer) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: directed scenario checks of the round-robin FIFO write arbiter
module tb_fifo_write_arbiter;
  logic w_clk = 0, w_rst = 1;
  logic [3:0] req_valid, req_ready;
  logic [31:0] req_data;
  logic wfull = 0, hfull = 0, w_inc, busy;
  logic [7:0] wdata;
  logic [1:0] grant_id;
  int vecs = 0, errs = 0;
  int len[4], cnt[4];
  logic [7:0] base[4];
  fifo_write_arbiter #(.N_REQ(4), .D_WIDTH(8), .BURST(4)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wfull(wfull), .hfull(hfull), .w_inc(w_inc),
    .wdata(wdata), .grant_id(grant_id), .busy(busy)
  );
  always #5 w_clk = ~w_clk;
  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = cnt[i] < len[i];
      req_data[i*8 +: 8] = base[i] + 8'(cnt[i]);
    end
  endtask
  task automatic clear();
    for (int i = 0; i < 4; i++) begin
      len[i] = 0;
      cnt[i] = 0;
      base[i] = 8'(i * 16);
    end
    wfull = 0;
    hfull = 0;
    apply();
  endtask
  task automatic advance();
    logic [3:0] acc;
    acc = req_valid & req_ready;
    @(posedge w_clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) cnt[i]++;
    apply();
  endtask
  task automatic do_reset();
    w_rst = 1;
    clear();
    @(posedge w_clk);
    #1;
    w_rst = 0;
  endtask
  task automatic test_reset();
    w_rst = 1;
    clear();
    repeat (2) @(posedge w_clk);
    #1;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b exp 0", busy); end
    vecs++; if (w_inc !== 1'b0) begin errs++; $display("FAIL reset_w_inc got %b exp 0", w_inc); end
    vecs++; if (req_ready !== 4'b0) begin errs++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    vecs++; if (wdata !== 8'h00) begin errs++; $display("FAIL reset_wdata got %h exp 00", wdata); end
    vecs++; if (grant_id !== 2'd0) begin errs++; $display("FAIL reset_grant got %0d exp 0", grant_id); end
    w_rst = 0;
  endtask
  task automatic test_single();
    bit exp_inc[11] = '{0, 1, 1, 1, 1, 0, 0, 1, 1, 0, 0};
    int nb = 0;
    do_reset();
    len[0] = 6;
    base[0] = 8'h10;
    apply();
    for (int c = 0; c < 11; c++) begin
      #4;
      vecs++; if (w_inc !== exp_inc[c]) begin errs++; $display("FAIL single_inc c=%0d got %b exp %b", c, w_inc, exp_inc[c]); end
      if (exp_inc[c]) begin
        vecs++; if (wdata !== 8'(8'h10 + nb)) begin errs++; $display("FAIL single_data c=%0d got %h exp %h", c, wdata, 8'(8'h10 + nb)); end
        vecs++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL single_ready c=%0d got %b exp 0001", c, req_ready); end
        nb++;
      end else begin
        vecs++; if (req_ready !== 4'b0000) begin errs++; $display("FAIL single_noready c=%0d got %b exp 0000", c, req_ready); end
      end
      advance();
    end
  endtask
  task automatic test_all();
    int k, ph, g;
    logic [7:0] ed;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      len[i] = 100;
      base[i] = 8'(i * 64);
    end
    apply();
    for (int c = 0; c < 30; c++) begin
      #4;
      k = (c - 1) / 6;
      ph = (c - 1) % 6;
      g = k % 4;
      if (c >= 1 && ph < 4) begin
        ed = 8'(g * 64 + (k / 4) * 4 + ph);
        vecs++; if (w_inc !== 1'b1) begin errs++; $display("FAIL all_inc c=%0d got %b exp 1", c, w_inc); end
        vecs++; if (grant_id !== 2'(g)) begin errs++; $display("FAIL all_grant c=%0d got %0d exp %0d", c, grant_id, g); end
        vecs++; if (wdata !== ed) begin errs++; $display("FAIL all_data c=%0d got %h exp %h", c, wdata, ed); end
        vecs++; if (req_ready !== 4'(1 << g)) begin errs++; $display("FAIL all_ready c=%0d got %b exp %b", c, req_ready, 4'(1 << g)); end
      end else begin
        vecs++; if (w_inc !== 1'b0) begin errs++; $display("FAIL all_gap c=%0d got %b exp 0", c, w_inc); end
      end
      advance();
    end
  endtask
  task automatic test_wfull();
    bit exp_inc[9] = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
    int nb = 0;
    do_reset();
    len[1] = 4;
    base[1] = 8'h20;
    apply();
    for (int c = 0; c < 9; c++) begin
      wfull = (c >= 3 && c <= 5);
      #4;
      vecs++; if (w_inc !== exp_inc[c]) begin errs++; $display("FAIL wfull_inc c=%0d got %b exp %b", c, w_inc, exp_inc[c]); end
      if (c >= 1 && c <= 7) begin
        vecs++; if (busy !== 1'b1 || grant_id !== 2'd1) begin errs++; $display("FAIL wfull_hold c=%0d got busy=%b grant=%0d exp busy=1 grant=1", c, busy, grant_id); end
      end
      if (wfull) begin
        vecs++; if (req_ready !== 4'b0) begin errs++; $display("FAIL wfull_ready c=%0d got %b exp 0000", c, req_ready); end
      end
      if (exp_inc[c]) begin
        vecs++; if (wdata !== 8'(8'h20 + nb)) begin errs++; $display("FAIL wfull_data c=%0d got %h exp %h", c, wdata, 8'(8'h20 + nb)); end
        nb++;
      end
      advance();
    end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL wfull_end got busy=%b exp 0", busy); end
  endtask
  task automatic test_hfull();
    int idx = 0;
    logic [7:0] ed;
    do_reset();
    hfull = 1;
    len[0] = 10;
    len[2] = 10;
    base[0] = 8'h30;
    base[2] = 8'h50;
    apply();
    for (int c = 0; c < 12; c++) begin
      #4;
      if (c % 3 == 1) begin
        ed = (idx % 2 == 0) ? 8'(8'h30 + idx / 2) : 8'(8'h50 + idx / 2);
        vecs++; if (w_inc !== 1'b1 || grant_id !== ((idx % 2 == 0) ? 2'd0 : 2'd2)) begin errs++; $display("FAIL hfull_grant c=%0d got inc=%b grant=%0d exp inc=1 grant=%0d", c, w_inc, grant_id, (idx % 2) * 2); end
        vecs++; if (wdata !== ed) begin errs++; $display("FAIL hfull_data c=%0d got %h exp %h", c, wdata, ed); end
        idx++;
      end else begin
        vecs++; if (w_inc !== 1'b0) begin errs++; $display("FAIL hfull_gap c=%0d got %b exp 0", c, w_inc); end
      end
      advance();
    end
  endtask
  task automatic test_drop();
    do_reset();
    len[3] = 1;
    base[3] = 8'h70;
    base[0] = 8'h90;
    base[2] = 8'hA0;
    apply();
    for (int c = 0; c < 11; c++) begin
      if (c == 2) begin
        len[0] = 1;
        len[2] = 1;
        apply();
      end
      #4;
      case (c)
        1: begin
          vecs++; if (w_inc !== 1'b1 || grant_id !== 2'd3 || wdata !== 8'h70) begin errs++; $display("FAIL drop_first got inc=%b grant=%0d data=%h exp inc=1 grant=3 data=70", w_inc, grant_id, wdata); end
        end
        2: begin
          vecs++; if (w_inc !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL drop_release got inc=%b busy=%b exp inc=0 busy=1", w_inc, busy); end
        end
        3: begin
          vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL drop_bubble got busy=%b exp 0", busy); end
        end
        5: begin
          vecs++; if (w_inc !== 1'b1 || grant_id !== 2'd0 || wdata !== 8'h90) begin errs++; $display("FAIL drop_wrap got inc=%b grant=%0d data=%h exp inc=1 grant=0 data=90", w_inc, grant_id, wdata); end
        end
        9: begin
          vecs++; if (w_inc !== 1'b1 || grant_id !== 2'd2 || wdata !== 8'hA0) begin errs++; $display("FAIL drop_next got inc=%b grant=%0d data=%h exp inc=1 grant=2 data=a0", w_inc, grant_id, wdata); end
        end
        default: begin
          vecs++; if (w_inc !== 1'b0) begin errs++; $display("FAIL drop_gap c=%0d got %b exp 0", c, w_inc); end
        end
      endcase
      advance();
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    len[1] = 10;
    base[1] = 8'h60;
    apply();
    repeat (3) advance();
    #1;
    vecs++; if (busy !== 1'b1 || w_inc !== 1'b1) begin errs++; $display("FAIL rstmid_pre got busy=%b inc=%b exp 1 1", busy, w_inc); end
    w_rst = 1;
    #1;
    vecs++; if (w_inc !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0 || grant_id !== 2'd0) begin errs++; $display("FAIL rstmid_async got inc=%b ready=%b busy=%b grant=%0d exp 0 0000 0 0", w_inc, req_ready, busy, grant_id); end
    len[0] = 10;
    base[0] = 8'h80;
    apply();
    @(posedge w_clk);
    #1;
    w_rst = 0;
    #4;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rstmid_arb got busy=%b exp 0", busy); end
    advance();
    #4;
    vecs++; if (w_inc !== 1'b1 || grant_id !== 2'd0 || wdata !== 8'h80) begin errs++; $display("FAIL rstmid_first got inc=%b grant=%0d data=%h exp inc=1 grant=0 data=80", w_inc, grant_id, wdata); end
    advance();
  endtask
  initial begin
    test_reset();
    test_single();
    test_all();
    test_wfull();
    test_hfull();
    test_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
